scu_dsp_dma_xfer: RTL and testbench
===================================

# scu_dsp_dma_xfer

Parametrised DMA transfer engine for the SCU DSP family; generalises the DSP's fixed four-bank, 8-bit-count, D0-bus transfer logic. Moves words between the external D0 bus and any of BANKS data RAM banks or the program RAM. It supports a full-range count, an abort, an end-of-bus handshake and an illegal-request error. It sits between the DSP sequencer (which issues START) and the SCU bus arbiter (REQ/ACK/END).

## Interface
- BANKS, 4, number of data RAM banks (2..8)
- DATA_W, 32, word width
- CNT_W, 8, count field width; COUNT=0 means 2^CNT_W words
- SEL_W, 4, select width; SEL[SEL_W-1]=1 selects program RAM, low bits select the data bank
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  DSP instruction clock enable
- CE_R  in  1  bus-phase enable; beats occur only when this is high
- START  in  1  request from the sequencer, sampled on CE
- DIR  in  1  0 = bus→RAM, 1 = RAM→bus
- SEL  in  SEL_W  target select
- COUNT  in  CNT_W  word count
- ABORT  in  1  synchronous cancel, effective on any clock
- BUS_DI  in  DATA_W  read data from the bus
- BUS_DO  out  DATA_W  write data; equals RAM_Q of the selected bank
- BUS_WE  out  1  equals the latched DIR while BUSY
- BUS_REQ  out  1  beat request
- BUS_ACK  in  1  beat accepted
- BUS_LAST  out  1  current beat is the final one
- BUS_END  in  1  arbiter finished the burst
- RAM_Q  in  BANKS*DATA_W  bank read data, bank k at [k*DATA_W +: DATA_W]
- RAM_D  out  DATA_W  write data (BUS_DI)
- RAM_WE  out  BANKS  one-hot bank write strobe
- CT_INC  out  BANKS  one-hot address-counter increment strobe
- PRG_WE  out  1  program RAM write strobe (also increments the PC)
- BUSY  out  1  transfer in progress (T0 flag)
- DONE  out  1  one-clock pulse at completion
- ERR  out  1  sticky illegal-request flag; cleared by the next accepted START

## Operation
- States: IDLE, XFER, WAIT_END, FIN.
- IDLE:
  - START & CE latches DIR, SEL and REM = (COUNT==0 ? 2^CNT_W : COUNT) into a CNT_W+1-bit register, then enters XFER.
  - If DIR=1 with program RAM selected, or the bank index is ≥ BANKS: set ERR and go to FIN with no beats.
- XFER:
  - BUS_REQ=1.
  - A beat occurs when CE_R & BUS_REQ & BUS_ACK:
    - REM decrements.
    - The selected CT_INC bit pulses.
    - If DIR=0, RAM_WE or PRG_WE pulses with RAM_D=BUS_DI. For program RAM, CT_INC stays 0 and PRG_WE serves as the increment.
  - BUS_LAST = (REM==1).
  - The beat with REM==1 clears BUS_REQ and moves to WAIT_END.
- WAIT_END: leaves for FIN on the first CE_R cycle with BUS_END=1.
- FIN: DONE=1 for one clock, BUSY drops, returns to IDLE.
- A START while not in IDLE is ignored; no state change.
- ABORT in any state goes to IDLE on the next clock. BUSY=0 and BUS_REQ=0. No DONE pulse, no strobes. ERR is unchanged.
- RAM_WE, PRG_WE and CT_INC are never asserted outside a beat.

## Timing
- Reset values: BUSY=0, BUS_REQ=0, BUS_LAST=0, DONE=0, ERR=0, RAM_WE=0, CT_INC=0, PRG_WE=0, BUS_WE=0, state IDLE.
- BUSY and BUS_REQ rise on the clock after START is accepted.
- BUS_DO and RAM_D are combinational from RAM_Q/BUS_DI. The strobes are combinational on the beat condition, one clock wide.
- Minimum transfer of N words: 1 (accept) + N beats + ≥1 (END) + 1 (FIN) clocks.
- ACK without CE_R is not a beat. REQ stays high across a stalled ACK.
- ABORT together with a beat: the beat's strobes still fire, then the block goes to IDLE.
- ABORT together with START in IDLE: ABORT wins, START is dropped.

## Test plan
- BANKS=4. DIR=0, SEL=2, COUNT=3, ACK every CE_R, BUS_DI=A0,A1,A2 -> RAM_WE=0100 three times with those data; CT_INC=0100 ×3; BUS_LAST on the 3rd beat; DONE one clock after BUS_END.
- DIR=1, SEL=1, COUNT=0 -> exactly 256 beats; BUS_WE=1; BUS_DO tracks RAM_Q bank 1; BUS_LAST only on beat 256.
- DIR=0, program RAM selected, COUNT=2 -> PRG_WE ×2; CT_INC stays 0.
- DIR=1, program RAM selected -> ERR=1; DONE pulses; zero beats; BUS_REQ never high.
- ABORT after beat 2 of 5 -> BUSY=0 and BUS_REQ=0 next clock; no DONE; no further strobes. A new START then runs normally.
- Second START mid-transfer, plus ACK held high with CE_R low -> START ignored; no beats counted until CE_R. RST_N low mid-XFER -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/scu_dsp_dma_xfer.sv
// DMA engine moving words between the D0 bus and a data RAM bank or program RAM.
// Strobes are combinational on the beat; BUS_REQ holds across stalled ACKs; ABORT returns to IDLE next clock.
module scu_dsp_dma_xfer #(
  parameter int BANKS  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CE,
  input  logic                    CE_R,
  input  logic                    START,
  input  logic                    DIR,
  input  logic [SEL_W-1:0]        SEL,
  input  logic [CNT_W-1:0]        COUNT,
  input  logic                    ABORT,
  input  logic [DATA_W-1:0]       BUS_DI,
  output logic [DATA_W-1:0]       BUS_DO,
  output logic                    BUS_WE,
  output logic                    BUS_REQ,
  input  logic                    BUS_ACK,
  output logic                    BUS_LAST,
  input  logic                    BUS_END,
  input  logic [BANKS*DATA_W-1:0] RAM_Q,
  output logic [DATA_W-1:0]       RAM_D,
  output logic [BANKS-1:0]        RAM_WE,
  output logic [BANKS-1:0]        CT_INC,
  output logic                    PRG_WE,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR
);

  localparam int BW = SEL_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT_END, S_FIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_dir;
  logic [SEL_W-1:0]    r_sel;
  logic [CNT_W:0]      r_rem;
  logic                r_err;

  logic                w_accept;
  logic                w_req_prg;
  logic                w_req_bad;
  logic                w_prg;
  logic [BW-1:0]       w_bank;
  logic [BANKS-1:0]    w_bank_oh;
  logic [DATA_W-1:0]   w_bus_do;
  logic                w_beat;
  logic                w_last;

  assign w_accept  = (r_state == S_IDLE) & START & CE & ~ABORT;
  assign w_req_prg = SEL[SEL_W-1];
  // Program RAM is write-only from the bus; bank indices past BANKS have no RAM behind them.
  assign w_req_bad = (DIR & w_req_prg) | (~w_req_prg & (32'(SEL[BW-1:0]) >= BANKS));

  assign w_prg  = r_sel[SEL_W-1];
  assign w_bank = r_sel[BW-1:0];
  assign w_beat = (r_state == S_XFER) & CE_R & BUS_ACK;
  assign w_last = (r_state == S_XFER) && (r_rem == (CNT_W+1)'(1));

  always_comb begin
    w_bank_oh = '0;
    w_bus_do  = '0;
    for (int k = 0; k < BANKS; k++) begin
      if (32'(w_bank) == k) begin
        w_bank_oh[k] = 1'b1;
        w_bus_do     = RAM_Q[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = w_req_bad ? S_FIN : S_XFER;
      S_XFER:     if (w_beat && w_last) w_next = S_WAIT_END;
      S_WAIT_END: if (CE_R && BUS_END) w_next = S_FIN;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (ABORT) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_sel   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir <= DIR;
        r_sel <= SEL;
        r_rem <= (COUNT == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, COUNT};
        r_err <= w_req_bad;
      end else if (w_beat) begin
        r_rem <= r_rem - (CNT_W+1)'(1);
      end
    end
  end

  assign BUSY     = (r_state != S_IDLE);
  assign DONE     = (r_state == S_FIN);
  assign ERR      = r_err;
  assign BUS_REQ  = (r_state == S_XFER);
  assign BUS_LAST = w_last;
  assign BUS_WE   = r_dir & BUSY;
  assign BUS_DO   = w_bus_do;
  assign RAM_D    = BUS_DI;
  // For program RAM the PC advances on PRG_WE, so no address counter is bumped.
  assign RAM_WE   = (w_beat & ~r_dir & ~w_prg) ? w_bank_oh : '0;
  assign CT_INC   = (w_beat & ~w_prg) ? w_bank_oh : '0;
  assign PRG_WE   = w_beat & ~r_dir & w_prg;

endmodule

// File: tb/tb_scu_dsp_dma_xfer.sv
// Randomised bench for scu_dsp_dma_xfer with a transaction-level reference model.
module tb_scu_dsp_dma_xfer;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CE, CE_R, START, DIR, ABORT, BUS_ACK, BUS_END;
  logic [3:0]   SEL;
  logic [7:0]   COUNT;
  logic [31:0]  BUS_DI, BUS_DO, RAM_D;
  logic [127:0] RAM_Q;
  logic [3:0]   RAM_WE, CT_INC;
  logic         BUS_WE, BUS_REQ, BUS_LAST, PRG_WE, BUSY, DONE, ERR;

  int n_vec = 0;
  int n_err = 0;
  logic err_model = 1'b0;

  always #5 CLK = ~CLK;

  scu_dsp_dma_xfer #(.BANKS(4), .DATA_W(32), .CNT_W(8), .SEL_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CE_R(CE_R), .START(START), .DIR(DIR),
    .SEL(SEL), .COUNT(COUNT), .ABORT(ABORT), .BUS_DI(BUS_DI), .BUS_DO(BUS_DO),
    .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ), .BUS_ACK(BUS_ACK), .BUS_LAST(BUS_LAST),
    .BUS_END(BUS_END), .RAM_Q(RAM_Q), .RAM_D(RAM_D), .RAM_WE(RAM_WE),
    .CT_INC(CT_INC), .PRG_WE(PRG_WE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, want);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ramwe"}, RAM_WE, 0);
    check({tag, "_ctinc"}, CT_INC, 0);
    check({tag, "_prgwe"}, PRG_WE, 0);
    check({tag, "_req"}, BUS_REQ, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_quiet(tag);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_last"}, BUS_LAST, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_buswe"}, BUS_WE, 0);
  endtask

  task automatic drive_idle();
    CE = 0; CE_R = 0; START = 0; DIR = 0; ABORT = 0; BUS_ACK = 0; BUS_END = 0;
    SEL = 0; COUNT = 0; BUS_DI = 0; RAM_Q = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 0;
    drive_idle();
    err_model = 0;
    repeat (2) @(negedge CLK);
    #1 check_reset_vals("reset");
    RST_N = 1;
  endtask

  // One transfer: abort_at / rst_at give the beat count at which to abort / reset (-1 = never).
  task automatic run_xfer(input logic dir, input logic [3:0] sel, input logic [7:0] cnt,
                          input int abort_at, input int rst_at, input bit stall);
    logic prg, bad, beat;
    int n, b, cyc;
    logic [3:0] oh;
    prg = sel[3];
    bad = (dir & prg) | (!prg && sel[2:0] >= 3'd4);
    n   = (cnt == 0) ? 256 : int'(cnt);
    oh  = prg ? 4'b0 : (4'b0001 << sel[1:0]);

    @(negedge CLK);
    START = 1; CE = 1; DIR = dir; SEL = sel; COUNT = cnt; CE_R = 1; BUS_ACK = 1; ABORT = 0;
    #1 check("acc_busy", BUSY, 0);
    check("acc_req", BUS_REQ, 0);
    @(posedge CLK);
    err_model = bad;
    @(negedge CLK);
    START = 0; DIR = $urandom; SEL = 4'($urandom); COUNT = 8'($urandom);

    if (bad) begin
      CE_R = 1; BUS_ACK = 1;
      #1 check("bad_done", DONE, 1);
      check("bad_err", ERR, 1);
      check_quiet("bad");
      @(posedge CLK);
      @(negedge CLK);
      #1 check("bad_done2", DONE, 0);
      check("bad_busy2", BUSY, 0);
      check("bad_err2", ERR, 1);
      check_quiet("bad2");
      return;
    end

    b = 0; cyc = 0;
    while (b < n) begin
      CE_R    = stall ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      BUS_ACK = $urandom_range(2) != 0;
      START   = $urandom_range(7) == 0;
      CE      = $urandom;
      BUS_DI  = $urandom;
      RAM_Q   = {$urandom, $urandom, $urandom, $urandom};
      ABORT   = (abort_at >= 0 && b == abort_at);
      if (rst_at >= 0 && b == rst_at) begin
        CE_R = 1; BUS_ACK = 1;
        RST_N = 0;
        err_model = 0;
        #1 check_reset_vals("midrst");
        @(negedge CLK);
        RST_N = 1;
        drive_idle();
        return;
      end
      beat = CE_R & BUS_ACK;
      #1 check("x_busy", BUSY, 1);
      check("x_req", BUS_REQ, 1);
      check("x_done", DONE, 0);
      check("x_last", BUS_LAST, (b == n - 1));
      check("x_buswe", BUS_WE, dir);
      check("x_ramwe", RAM_WE, (beat && !dir) ? oh : 4'b0);
      check("x_ctinc", CT_INC, beat ? oh : 4'b0);
      check("x_prgwe", PRG_WE, beat & !dir & prg);
      check("x_ramd", RAM_D, BUS_DI);
      if (!prg) check("x_busdo", BUS_DO, RAM_Q[sel[1:0]*32 +: 32]);
      @(posedge CLK);
      if (beat) b++;
      @(negedge CLK);
      if (ABORT) begin
        ABORT = 0; START = 0; CE_R = 1; BUS_ACK = 1; BUS_END = 1;
        for (int i = 0; i < 3; i++) begin
          #1 check("ab_busy", BUSY, 0);
          check("ab_done", DONE, 0);
          check("ab_err", ERR, err_model);
          check_quiet("ab");
          @(negedge CLK);
        end
        drive_idle();
        return;
      end
      cyc++;
      if (cyc > 3000) begin
        check("xfer_timeout", 1, 0);
        apply_reset();
        return;
      end
    end

    START = 0; cyc = 0;
    forever begin
      CE_R = $urandom; BUS_END = $urandom_range(2) == 0; BUS_ACK = $urandom;
      #1 check("w_busy", BUSY, 1);
      check("w_done", DONE, 0);
      check("w_last", BUS_LAST, 0);
      check_quiet("w");
      @(posedge CLK);
      if (CE_R & BUS_END) break;
      @(negedge CLK);
      cyc++;
      if (cyc > 200) begin
        check("end_timeout", 1, 0);
        apply_reset();
        return;
      end
    end
    @(negedge CLK);
    BUS_END = 0; CE_R = 1; BUS_ACK = 1;
    #1 check("f_done", DONE, 1);
    check("f_err", ERR, 0);
    check_quiet("f");
    @(posedge CLK);
    @(negedge CLK);
    #1 check("f_done2", DONE, 0);
    check("f_busy2", BUSY, 0);
    check_quiet("f2");
    drive_idle();
  endtask

  initial begin
    RST_N = 0;
    drive_idle();
    apply_reset();

    run_xfer(1'b0, 4'd2, 8'd3, -1, -1, 1'b0);
    run_xfer(1'b1, 4'd1, 8'd0, -1, -1, 1'b0);
    run_xfer(1'b0, 4'b1000, 8'd2, -1, -1, 1'b0);
    run_xfer(1'b1, 4'b1000, 8'd5, -1, -1, 1'b0);
    run_xfer(1'b0, 4'd5, 8'd4, -1, -1, 1'b0);
    run_xfer(1'b1, 4'd3, 8'd2, -1, -1, 1'b0);
    run_xfer(1'b0, 4'd0, 8'd5, 2, -1, 1'b0);
    run_xfer(1'b0, 4'd3, 8'd4, -1, -1, 1'b0);
    run_xfer(1'b1, 4'd2, 8'd6, -1, -1, 1'b1);
    run_xfer(1'b0, 4'd1, 8'd10, -1, 3, 1'b0);

    // ABORT wins over a simultaneous START in IDLE.
    @(negedge CLK);
    START = 1; CE = 1; ABORT = 1; SEL = 4'd1; COUNT = 8'd3;
    @(negedge CLK);
    START = 0; ABORT = 0; CE_R = 1; BUS_ACK = 1;
    #1 check("abst_busy", BUSY, 0);
    check_quiet("abst");
    drive_idle();

    for (int t = 0; t < 20; t++) begin
      logic [3:0] s;
      logic [7:0] c;
      s = 4'($urandom_range(15));
      c = ($urandom_range(15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      run_xfer(1'($urandom), s, c, ($urandom_range(4) == 0) ? int'($urandom_range(0, 2)) : -1,
               -1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
